multicycle_controller: RTL

- Moore FSM control unit for a multicycle RV32I datapath (subset: lw, sw, R-type, I-type ALU, beq, jal).
- Sequences instruction memory, register file, ALU operand muxes and the immediate extender (drives its 2-bit ImmSrc) from the fetched opcode.
- Shares one memory port between instruction fetch and data access via AdrSrc.

---
 rtl/multicycle_controller.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Moore FSM control unit for a multicycle RV32I datapath (lw, sw, R-type, I-type ALU, beq, jal).
// Define ILLEGAL_TRAP_EN to build the TRAP state and sticky illegal flag; otherwise unsupported ops are NOPs.
module multicycle_controller #(
    parameter int MEM_LAT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [2:0] LAT     = 3'(MEM_LAT);

    state_t     cur_state, nxt_state;
    logic [2:0] wait_cnt, wait_cnt_nxt;
    logic       wait_done;
    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= S_FETCH;
            wait_cnt  <= '0;
        end else begin
            cur_state <= nxt_state;
            wait_cnt  <= wait_cnt_nxt;
        end
    end

    // The counter only runs inside the memory-wait states, so it is zero on every entry to them.
    assign wait_done = (wait_cnt == LAT);

    always_comb begin
        wait_cnt_nxt = '0;
        if ((cur_state == S_FETCH || cur_state == S_MEMREAD) && !wait_done)
            wait_cnt_nxt = wait_cnt + 3'd1;
    end

    always_comb begin
        nxt_state = cur_state;
        unique case (cur_state)
            S_FETCH:    nxt_state = wait_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (op)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_R:         nxt_state = S_EXECUTER;
                    OP_I:         nxt_state = S_EXECUTEI;
                    OP_BEQ:       nxt_state = S_BEQ;
                    OP_JAL:       nxt_state = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:      nxt_state = S_TRAP;
`else
                    default:      nxt_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   nxt_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  nxt_state = wait_done ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    nxt_state = S_FETCH;
            S_MEMWRITE: nxt_state = S_FETCH;
            S_EXECUTER: nxt_state = S_ALUWB;
            S_EXECUTEI: nxt_state = S_ALUWB;
            S_ALUWB:    nxt_state = S_FETCH;
            S_BEQ:      nxt_state = S_FETCH;
            S_JAL:      nxt_state = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     nxt_state = S_TRAP;
`endif
            default:    nxt_state = S_FETCH;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        RegWrite  = 1'b0;
        alu_op    = 2'b00;
        pc_update = 1'b0;
        branch    = 1'b0;
        unique case (cur_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = wait_done;
                pc_update = wait_done;
            end
            S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
            S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
            S_MEMWRITE: begin AdrSrc = 1'b1; MemWrite = 1'b1; end
            S_EXECUTER: begin ALUSrcA = 2'b10; alu_op = 2'b10; end
            S_EXECUTEI: begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; alu_op = 2'b10; end
            S_ALUWB:    RegWrite = 1'b1;
            S_BEQ:      begin ALUSrcA = 2'b10; alu_op = 2'b01; branch = 1'b1; end
            S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_update = 1'b1; end
            default:    ;
        endcase
    end

    assign PCWrite = pc_update | (branch & Zero);
    assign state   = cur_state;

`ifdef ILLEGAL_TRAP_EN
    // TRAP only exits through reset, so the flag is sticky by construction.
    assign illegal = (cur_state == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        unique case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        unique case (alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            default: begin
                unique case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
        endcase
    end

endmodule
